// File: rtl/dram_fifo32_ctrl.sv
// Pointer, flag and output-register stage for a 32-entry FIFO built on a
// 32-deep distributed RAM with asynchronous read and synchronous write.
module dram_fifo32_ctrl #(
  parameter int DW         = 16,
  parameter int AFULL_THR  = 28,
  parameter int AEMPTY_THR = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CLR,
  input  logic          PUSH,
  input  logic [DW-1:0] DIN,
  input  logic          POP,
  output logic [DW-1:0] DOUT,
  output logic          DVALID,
  output logic          FULL,
  output logic          EMPTY,
  output logic          ALMOST_FULL,
  output logic          ALMOST_EMPTY,
  output logic [5:0]    COUNT,
  output logic          OVERFLOW,
  output logic          UNDERFLOW,
  output logic          RAM_WE,
  output logic [4:0]    RAM_WADDR,
  output logic [4:0]    RAM_RADDR,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO
);

  localparam logic [6:0] AFULL_T  = 7'(AFULL_THR);
  localparam logic [6:0] AEMPTY_T = 7'(AEMPTY_THR);

  logic [5:0]    wr_ptr;
  logic [5:0]    rd_ptr;
  logic [5:0]    occupancy;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic [DW-1:0] dout_q;
  logic          dvalid_q;
  logic          overflow_q;
  logic          underflow_q;

  // Flags come only from the registered pointers; the 6th bit tells full from empty.
  always_comb begin
    occupancy = wr_ptr - rd_ptr;
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[4:0] == rd_ptr[4:0]) && (wr_ptr[5] != rd_ptr[5]);
    push_ok   = PUSH && !full;
    pop_ok    = POP && !empty;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (CLR) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 6'd1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 6'd1;
        dout_q   <= RAM_DO;
        dvalid_q <= 1'b1;
      end else begin
        dvalid_q <= 1'b0;
      end
      if (PUSH && full) begin
        overflow_q <= 1'b1;
      end
      if (POP && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // The write strobe is gated by reset and clear so a discarded request never lands in RAM.
  always_comb begin
    RAM_WE       = push_ok && RST_N && !CLR;
    RAM_WADDR    = wr_ptr[4:0];
    RAM_RADDR    = rd_ptr[4:0];
    RAM_DI       = DIN;
    COUNT        = occupancy;
    FULL         = full;
    EMPTY        = empty;
    ALMOST_FULL  = ({1'b0, occupancy} >= AFULL_T);
    ALMOST_EMPTY = ({1'b0, occupancy} <= AEMPTY_T);
    DOUT         = dout_q;
    DVALID       = dvalid_q;
    OVERFLOW     = overflow_q;
    UNDERFLOW    = underflow_q;
  end

endmodule
